// File: rtl/ov7670_sccb_responder.sv
`timescale 1ns/1ps
// ov7670_sccb_responder
//   Camera-side SCCB target for the OV7670 register bus. SIO_C/SIO_D are
//   oversampled on clk. The block decodes START/STOP and the ID, sub-address
//   and data phases. It acks matching writes and pulses wr_strobe once per
//   completed 3-phase write.
//
//   Optional feature: define OV7670_SCCB_RESP_READ_EN to ack the read ID
//   (DEV_ID|1) and shift rd_data out on SIO_D. When it is undefined, the read
//   ID is treated as a foreign ID and rd_data is ignored.
//
// Ports
//   clk        system clock, at least 8x SIO_C
//   rst_n      asynchronous active-low reset
//   sioc_in    SIO_C pin level
//   siod_in    SIO_D pin level (wired-AND bus)
//   siod_oe    1 = pull SIO_D low (open-drain pad)
//   wr_strobe  one-cycle pulse when a 3-phase write completes
//   wr_addr    sub-address of the last write
//   wr_data    data of the last write
//   rd_addr    last sub-address received
//   rd_data    register contents at rd_addr (read feature only)
//   bus_busy   high from START until STOP
module ov7670_sccb_responder #(
  parameter logic [7:0] DEV_ID      = 8'h42,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sioc_in,
  input  logic       siod_in,
  output logic       siod_oe,
  output logic       wr_strobe,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       bus_busy
);

  typedef enum logic [3:0] {
    IDLE, ID, ID_ACK, ADDR, ADDR_ACK, DATA, DATA_ACK, RD_BITS, RD_NA, IGNORE
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_prev_q, sda_prev_q;
  logic                   scl_s, sda_s;
  logic                   scl_rise, scl_fall, start_det, stop_det;

  state_t     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] byte_nxt;
  logic       oe_q, oe_d;
  logic       strobe_q, strobe_d;
  logic [7:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic [7:0] rd_addr_q, rd_addr_d;
  logic       busy_q, busy_d;
  logic       is_read_q, is_read_d;

  // Synchroniser plus one history flop for edge detection. An idle bus is
  // high, so reset to 1 to avoid a spurious edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], sioc_in};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], siod_in};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

  assign scl_s    = scl_sync_q[SYNC_STAGES-1];
  assign sda_s    = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise = ~scl_prev_q & scl_s;
  assign scl_fall = scl_prev_q & ~scl_s;
  // SCL must be high in both samples. If SCL and SDA move together in one
  // sample, the event is a clock edge, not a bus condition.
  assign start_det = scl_prev_q & scl_s & sda_prev_q & ~sda_s;
  assign stop_det  = scl_prev_q & scl_s & ~sda_prev_q & sda_s;
  assign byte_nxt  = {shift_q[6:0], sda_s};

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    oe_d      = oe_q;
    strobe_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    rd_addr_d = rd_addr_q;
    busy_d    = busy_q;
    is_read_d = is_read_q;
    if (start_det) begin
      state_d   = ID;
      bit_cnt_d = 3'd0;
      oe_d      = 1'b0;
      busy_d    = 1'b1;
    end else if (stop_det) begin
      state_d   = IDLE;
      bit_cnt_d = 3'd0;
      oe_d      = 1'b0;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        ID, ADDR, DATA: begin
          if (scl_rise) begin
            shift_d   = byte_nxt;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (state_q == ID) begin
                is_read_d = 1'b0;
                if (byte_nxt == DEV_ID) begin
                  state_d = ID_ACK;
`ifdef OV7670_SCCB_RESP_READ_EN
                end else if (byte_nxt == (DEV_ID | 8'h01)) begin
                  state_d   = ID_ACK;
                  is_read_d = 1'b1;
`endif
                end else begin
                  state_d = IGNORE;
                end
              end else if (state_q == ADDR) begin
                rd_addr_d = byte_nxt;
                state_d   = ADDR_ACK;
              end else begin
                wr_addr_d = rd_addr_q;
                wr_data_d = byte_nxt;
                strobe_d  = 1'b1;
                state_d   = DATA_ACK;
              end
            end
          end
        end
        // The first falling edge starts driving the ack. The second falling
        // edge ends the 9th clock and releases the line.
        ID_ACK, ADDR_ACK, DATA_ACK: begin
          if (scl_fall) begin
            if (!oe_q) begin
              oe_d = 1'b1;
            end else begin
              oe_d      = 1'b0;
              bit_cnt_d = 3'd0;
              if (state_q == ADDR_ACK) begin
                state_d = DATA;
              end else if (state_q == DATA_ACK) begin
                state_d = IGNORE;
              end else begin
`ifdef OV7670_SCCB_RESP_READ_EN
                if (is_read_q) begin
                  // This edge also presents the MSB of the read byte.
                  state_d = RD_BITS;
                  shift_d = rd_data;
                  oe_d    = ~rd_data[7];
                end else begin
                  state_d = ADDR;
                end
`else
                state_d = ADDR;
`endif
              end
            end
          end
        end
        RD_BITS: begin
          if (scl_fall) begin
            if (bit_cnt_q == 3'd7) begin
              oe_d      = 1'b0;
              bit_cnt_d = 3'd0;
              state_d   = RD_NA;
            end else begin
              shift_d   = {shift_q[6:0], 1'b0};
              oe_d      = ~shift_q[6];
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end
        end
        RD_NA: begin
          if (scl_rise) state_d = IGNORE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'd0;
      oe_q      <= 1'b0;
      strobe_q  <= 1'b0;
      wr_addr_q <= 8'd0;
      wr_data_q <= 8'd0;
      rd_addr_q <= 8'd0;
      busy_q    <= 1'b0;
      is_read_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      oe_q      <= oe_d;
      strobe_q  <= strobe_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      rd_addr_q <= rd_addr_d;
      busy_q    <= busy_d;
      is_read_q <= is_read_d;
    end
  end

`ifndef OV7670_SCCB_RESP_READ_EN
  logic unused_rd;
  assign unused_rd = ^{rd_data, is_read_q};
`endif

  assign siod_oe   = oe_q;
  assign wr_strobe = strobe_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign rd_addr   = rd_addr_q;
  assign bus_busy  = busy_q;

endmodule
